// File: rtl/riscv_mem_pkg.sv
// Shared memory-stage constants: load/store funct3 codes
// and the MemToReg select encodings used by the write-back mux.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10
  } mem_to_reg_e;

endpackage

// File: rtl/lsu_align.sv
// Load/store alignment: lane select + extend on load, byte enables + replication on store,
// misalignment detection. Ports: funct3, addr_lo, mem_read/write, rdata, store_data -> load_data, wdata, byte_en, misaligned.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] rdata,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic        misaligned
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        load_ok;
  logic        store_ok;
  logic        mis_sz;
  logic        sext;
  logic [31:0] rsh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld;
  logic [3:0]  be_raw;

  always_comb begin
    is_b     = (funct3[1:0] == 2'b00);
    is_h     = (funct3[1:0] == 2'b01);
    is_w     = (funct3[1:0] == 2'b10);
    load_ok  = (funct3 == F3_B)  || (funct3 == F3_H)
            || (funct3 == F3_W)  || (funct3 == F3_BU)
            || (funct3 == F3_HU);
    store_ok = (funct3 == F3_B) || (funct3 == F3_H)
            || (funct3 == F3_W);
    mis_sz   = (is_h && addr_lo[0])
            || (is_w && (addr_lo != 2'b00));
    sext     = ~funct3[2];
    rsh      = rdata >> {addr_lo, 3'b000};
    byte_v   = rsh[7:0];
    half_v   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ld       = '0;
    wdata    = '0;
    be_raw   = '0;

    unique case (1'b1)
      is_b: begin
        ld     = {{24{sext & byte_v[7]}}, byte_v};
        wdata  = {4{store_data[7:0]}};
        be_raw = 4'b0001 << addr_lo;
      end
      is_h: begin
        ld     = {{16{sext & half_v[15]}}, half_v};
        wdata  = {2{store_data[15:0]}};
        be_raw = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      is_w: begin
        ld     = rdata;
        wdata  = store_data;
        be_raw = 4'b1111;
      end
      default: begin
        ld     = '0;
        wdata  = '0;
        be_raw = '0;
      end
    endcase

    // Illegal encodings never count as misaligned.
    misaligned = (mem_read  && load_ok  && mis_sz)
              || (mem_write && store_ok && mis_sz);
    load_data  = (mem_read && load_ok && !mis_sz) ? ld : '0;
    byte_en    = (mem_write && store_ok && !mis_sz) ? be_raw : 4'b0000;
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with combinational reads, synchronous byte-lane writes
// and a sticky first-misaligned-access fault register.
module data_memory
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] mem_data,
  output logic        misaligned,
  output logic        fault_sticky,
  output logic [31:0] fault_addr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   mem_d [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   rdata;
  logic [31:0]   wdata;
  logic [3:0]    byte_en;
  logic          fault_sticky_q;
  logic          fault_sticky_d;
  logic [31:0]   fault_addr_q;
  logic [31:0]   fault_addr_d;

  // Upper address bits are dropped: addresses wrap.
  assign idx   = addr[AW+1:2];
  assign rdata = mem_q[idx];

  lsu_align u_align (
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .rdata      (rdata),
    .store_data (store_data),
    .load_data  (mem_data),
    .wdata      (wdata),
    .byte_en    (byte_en),
    .misaligned (misaligned)
  );

  always_comb begin
    mem_d = mem_q;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) begin
        mem_d[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    fault_sticky_d = fault_sticky_q | misaligned;
    fault_addr_d   = (misaligned && !fault_sticky_q) ? addr : fault_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      fault_sticky_q <= 1'b0;
      fault_addr_q   <= '0;
    end else begin
      mem_q          <= mem_d;
      fault_sticky_q <= fault_sticky_d;
      fault_addr_q   <= fault_addr_d;
    end
  end

  assign fault_sticky = fault_sticky_q;
  assign fault_addr   = fault_addr_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed vector table, hand-written fault/reset
// sequences and random traffic against a byte-array reference model.
module tb_data_memory;

  localparam int DW = 256;
  localparam int NB = DW * 4;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_data;
  logic        misaligned;
  logic        fault_sticky;
  logic [31:0] fault_addr;

  data_memory #(.DEPTH_WORDS(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .mem_data     (mem_data),
    .misaligned   (misaligned),
    .fault_sticky (fault_sticky),
    .fault_addr   (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  logic [7:0]  mb [NB];
  logic        m_sticky;
  logic [31:0] m_faddr;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] ed;
    logic        em;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit rd_legal(input logic [2:0] f3);
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic bit wr_legal(input logic [2:0] f3);
    return f3 < 3'd3;
  endfunction

  function automatic bit m_mis(input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a);
    bit mc;
    mc = (a % nbytes(f3)) != 0;
    return (rd && rd_legal(f3) && mc) || (wr && wr_legal(f3) && mc);
  endfunction

  function automatic logic [31:0] m_load(input logic rd, input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] v;
    int base;
    int n;
    n = nbytes(f3);
    if (!rd || !rd_legal(f3) || (a % n) != 0) return 32'h0;
    base = int'(a % NB);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[base+k]) << (8*k));
    if (f3 < 3'd4 && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
    m_sticky = 1'b0;
    m_faddr  = 32'h0;
  endtask

  task automatic m_commit();
    int base;
    int n;
    logic [31:0] s;
    n = nbytes(funct3);
    if (mem_write && wr_legal(funct3) && (addr % n) == 0) begin
      base = int'(addr % NB);
      s = store_data;
      for (int k = 0; k < n; k++) begin
        mb[base+k] = s[7:0];
        s = s >> 8;
      end
    end
    if (m_mis(mem_read, mem_write, funct3, addr) && !m_sticky) begin
      m_sticky = 1'b1;
      m_faddr  = addr;
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    m_commit();
    #1;
    chk("fault_sticky", 32'(fault_sticky), 32'(m_sticky));
    chk("fault_addr", fault_addr, m_faddr);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] ed, input logic em);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a;
    v.sd = sd; v.ed = ed; v.em = em;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_fail = 0;
    m_reset();
    rst_n = 1'b0;
    mem_read = 0; mem_write = 0; funct3 = 3'd2; addr = 0; store_data = 0;

    tv[0]  = mk(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    tv[1]  = mk(1, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    tv[2]  = mk(1, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
    tv[3]  = mk(1, 0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0);
    tv[4]  = mk(1, 0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 0);
    tv[5]  = mk(1, 0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 0);
    tv[6]  = mk(0, 1, 3'b010, 32'h20,  32'h0,        32'h0,        0);
    tv[7]  = mk(0, 1, 3'b000, 32'h21,  32'hAB,       32'h0,        0);
    tv[8]  = mk(0, 1, 3'b001, 32'h22,  32'h1234,     32'h0,        0);
    tv[9]  = mk(1, 0, 3'b010, 32'h20,  32'h0,        32'h1234AB00, 0);
    tv[10] = mk(0, 1, 3'b010, 32'h400, 32'h55,       32'h0,        0);
    tv[11] = mk(1, 0, 3'b010, 32'h000, 32'h0,        32'h00000055, 0);
    tv[12] = mk(0, 0, 3'b010, 32'h000, 32'h0,        32'h0,        0);
    tv[13] = mk(1, 0, 3'b011, 32'h001, 32'h0,        32'h0,        0);
    tv[14] = mk(1, 1, 3'b010, 32'h40,  32'h11223344, 32'h0,        0);
    tv[15] = mk(1, 0, 3'b010, 32'h40,  32'h0,        32'h11223344, 0);

    #1;
    chk("reset mem_data", mem_data, 32'h0);
    chk("reset fault_sticky", 32'(fault_sticky), 32'h0);
    chk("reset fault_addr", fault_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].rd, tv[i].wr, tv[i].f3, tv[i].a, tv[i].sd);
      chk($sformatf("vec%0d mem_data", i), mem_data, tv[i].ed);
      chk($sformatf("vec%0d misaligned", i), 32'(misaligned), 32'(tv[i].em));
      commit();
    end
    chk("no fault after table", 32'(fault_sticky), 32'h0);

    drive(0, 1, 3'b010, 32'h30, 32'hCAFEF00D);
    commit();
    drive(0, 1, 3'b001, 32'h31, 32'hFFFF);
    chk("sh31 misaligned", 32'(misaligned), 32'h1);
    commit();
    chk("sh31 sticky", 32'(fault_sticky), 32'h1);
    chk("sh31 fault_addr", fault_addr, 32'h31);
    drive(1, 0, 3'b010, 32'h30, 32'h0);
    chk("word30 unchanged", mem_data, 32'hCAFEF00D);
    commit();
    drive(1, 0, 3'b010, 32'h42, 32'h0);
    chk("lw42 misaligned", 32'(misaligned), 32'h1);
    chk("lw42 mem_data", mem_data, 32'h0);
    commit();
    chk("fault_addr kept", fault_addr, 32'h31);

    for (int r = 0; r < 300; r++) begin
      logic rd;
      logic wr;
      logic [2:0] f3;
      logic [31:0] a;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom & 32'hFFFF_F03F;
      drive(rd, wr, f3, a, $urandom);
      chk("rand mem_data", mem_data, m_load(rd, f3, a));
      chk("rand misaligned", 32'(misaligned), 32'(m_mis(rd, wr, f3, a)));
      commit();
    end

    drive(1, 0, 3'b010, 32'h10, 32'h0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("async rst mem_data", mem_data, 32'h0);
    chk("async rst sticky", 32'(fault_sticky), 32'h0);
    chk("async rst fault_addr", fault_addr, 32'h0);
    drive(0, 1, 3'b010, 32'h50, 32'h77);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 0, 3'b010, 32'h50, 32'h0);
    chk("store at release lost", mem_data, 32'h0);
    commit();
    drive(0, 1, 3'b010, 32'h50, 32'h77);
    commit();
    drive(1, 0, 3'b010, 32'h50, 32'h0);
    chk("store after release", mem_data, 32'h77);
    commit();
    drive(1, 0, 3'b010, 32'h10, 32'h0);
    chk("cleared word10", mem_data, 32'h0);
    commit();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory with the RISC-V load/store alignment logic, sitting between the ALU (address source) and the write-back mux (consumer of `mem_data`, selected when MemToReg = 01). It performs byte, halfword and word accesses, sign- or zero-extends loads, and merges stores. A sticky fault register records the first misaligned access. Reads are combinational and writes are synchronous, as the single-cycle datapath requires.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; must be a power of two, at least 4.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load enable from the control unit.
- `mem_write`  in  1  store enable from the control unit.
- `funct3`  in  3  access size and signedness, taken from the instruction.
- `addr`  in  32  byte address (ALU result).
- `store_data`  in  32  rs2 value; the low bytes are used for SB/SH.
- `mem_data`  out  32  extended load result, fed to the write-back mux.
- `misaligned`  out  1  combinational flag: the current enabled access is misaligned.
- `fault_sticky`  out  1  registered; set on the first misaligned access.
- `fault_addr`  out  32  registered; holds the address of the first misaligned access.

## Operation
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the memory size.
- Load encodings:
  - 000 LB, 001 LH, 010 LW: sign-extended.
  - 100 LBU, 101 LHU: zero-extended.
- Store encodings: 000 SB, 001 SH, 010 SW. Any other `funct3` with `mem_write` is illegal.
- Lane selection: the byte lane is `addr[1:0]`, the halfword lane is `addr[1]`, and the machine is little-endian.
- Misalignment conditions:
  - halfword access with `addr[0]` = 1;
  - word access with `addr[1:0]` ≠ 0.
  - `misaligned` is asserted only while `mem_read` or `mem_write` is high.
- `mem_data` is 0 in each of these cases:
  - `mem_read` = 0;
  - the load is misaligned;
  - `funct3` is illegal (011, 110, 111).
- Stores:
  - Only the selected byte lanes are written; the other lanes keep their value.
  - Misaligned or illegal stores are suppressed and leave memory unchanged.
- If `mem_read` and `mem_write` are both high, `mem_data` shows the contents before the write, and the write commits at the edge.
- Fault register:
  - At a rising edge with `misaligned` = 1 and `fault_sticky` = 0, set `fault_sticky` and capture `addr` into `fault_addr`.
  - Later faults do not overwrite `fault_addr`.
  - Illegal `funct3` does not set the fault.
  - Only reset clears the fault register.

## Timing
- Load latency is zero cycles: `mem_data` is a combinational function of the array state, `addr`, `funct3` and `mem_read` in the same cycle.
- Store latency is one edge: the new data becomes visible to combinational reads immediately after the rising edge.
- Reset values: every memory word is 0, `fault_sticky` = 0, `fault_addr` = 0. `mem_data` therefore reads 0 during and after reset.
- Asserting `rst_n` low mid-cycle clears state immediately. A store pending at the same edge as reset is lost, because reset wins.
- Releasing `rst_n` at a rising edge does not commit that edge's store. The first write happens on the first edge after deassertion.

## Structure
- Shared package `riscv_mem_pkg` holds:
  - the `funct3` constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - the MemToReg encodings (00 ALU, 01 MEM, 10 PC+4), shared with the write-back mux.
- Sub-module `lsu_align` is purely combinational and performs:
  - lane-select and extend on load;
  - byte-enable and data replication on store;
  - misaligned and illegal detection.
- The top level holds the array, the write port and the fault register.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 → `mem_data` 0xDEADBEEF. Then LB 0x13 → 0xFFFFFFDE, LBU 0x13 → 0x000000DE, LH 0x12 → 0xFFFFDEAD, LHU 0x10 → 0x0000BEEF.
- SW 0x00000000 to 0x20, then SB 0xAB to 0x21 and SH 0x1234 to 0x22. LW 0x20 → 0x1234AB00.
- SH to 0x31 with `store_data` 0xFFFF → store suppressed, and word 0x30 is unchanged. `misaligned` = 1 that cycle. After the edge, `fault_sticky` = 1 and `fault_addr` = 0x31. A later LW 0x42 keeps `fault_addr` = 0x31.
- With `DEPTH_WORDS` = 256: SW 0x55 to 0x400, then LW 0x000 → 0x00000055 (wrap). `mem_read` = 0 → `mem_data` 0. `funct3` 011 with `mem_read` → 0, and no fault is set.
- Pull `rst_n` low asynchronously mid-cycle after the fault and the stores above → all loads return 0, `fault_sticky` = 0, `fault_addr` = 0 immediately. A store asserted at the reset-release edge is not committed.
